// File: rtl/ball_motion_pkg.sv
// Shared types for the ball motion stage: fixed-point object, FSM states, default geometry
// and the strict AABB overlap test used for paddle hits.
package ball_motion_pkg;
    localparam int FBITS = 4;
    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] width;
        logic [WIDTH-1:0] height;
    } object;

    typedef enum logic [1:0] {SERVE, MOVE, OUT} ball_state_e;

    localparam logic [WIDTH-1:0] DEF_SCREEN_WIDTH  = WIDTH'(640 << FBITS);
    localparam logic [WIDTH-1:0] DEF_SCREEN_HEIGHT = WIDTH'(480 << FBITS);
    localparam logic [WIDTH-1:0] DEF_BALL_SIZE     = WIDTH'(16 << FBITS);
    localparam logic [WIDTH-1:0] DEF_SPEED_X       = WIDTH'(2 << FBITS);
    localparam logic [WIDTH-1:0] DEF_SPEED_Y       = WIDTH'(1 << FBITS);

    // Edges are summed one bit wider so a box near the top of the range cannot wrap.
    function automatic logic overlap(object a, object b);
        logic [WIDTH:0] a_right;
        logic [WIDTH:0] a_bottom;
        logic [WIDTH:0] b_right;
        logic [WIDTH:0] b_bottom;
        a_right  = {1'b0, a.x} + {1'b0, a.width};
        a_bottom = {1'b0, a.y} + {1'b0, a.height};
        b_right  = {1'b0, b.x} + {1'b0, b.width};
        b_bottom = {1'b0, b.y} + {1'b0, b.height};
        return ({1'b0, a.x} < b_right) && ({1'b0, b.x} < a_right) &&
               ({1'b0, a.y} < b_bottom) && ({1'b0, b.y} < a_bottom);
    endfunction
endpackage

// File: rtl/ball_motion_step.sv
// One frame of ball motion: wall bounce on Y, paddle bounce or exit detection on X.
// Purely combinational; the caller decides when to commit the result.
module ball_step
    import ball_motion_pkg::*;
#(
    parameter logic [WIDTH-1:0] SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter logic [WIDTH-1:0] SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter logic [WIDTH-1:0] BALL_SIZE     = DEF_BALL_SIZE,
    parameter logic [WIDTH-1:0] SPEED_X       = DEF_SPEED_X,
    parameter logic [WIDTH-1:0] SPEED_Y       = DEF_SPEED_Y
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_dir_left,
    input  logic             i_dir_up,
    input  object            i_paddle1,
    input  object            i_paddle2,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_y,
    output logic             o_dir_left,
    output logic             o_dir_up,
    output logic             o_exit
);
    logic [WIDTH:0]   w_y_reach;
    logic [WIDTH-1:0] w_nx;
    object            w_ball_nxt;

    always_comb begin
        o_y       = i_y;
        o_dir_up  = i_dir_up;
        w_y_reach = {1'b0, i_y} + {1'b0, BALL_SIZE} + {1'b0, SPEED_Y};
        if (i_dir_up && (i_y <= SPEED_Y)) begin
            o_y      = '0;
            o_dir_up = 1'b0;
        end else if (!i_dir_up && (w_y_reach >= {1'b0, SCREEN_HEIGHT})) begin
            o_y      = SCREEN_HEIGHT - BALL_SIZE;
            o_dir_up = 1'b1;
        end else if (i_dir_up) begin
            o_y = i_y - SPEED_Y;
        end else begin
            o_y = i_y + SPEED_Y;
        end
    end

    // Moving left from x < SPEED_X wraps nx far past the screen; the score stage relies on that.
    always_comb begin
        w_nx       = i_dir_left ? (i_x - SPEED_X) : (i_x + SPEED_X);
        w_ball_nxt = '{x: w_nx, y: o_y, width: BALL_SIZE, height: BALL_SIZE};
        o_x        = w_nx;
        o_dir_left = i_dir_left;
        o_exit     = 1'b0;
        if (i_dir_left && overlap(w_ball_nxt, i_paddle1)) begin
            o_x        = i_paddle1.x + i_paddle1.width;
            o_dir_left = 1'b0;
        end else if (!i_dir_left && overlap(w_ball_nxt, i_paddle2)) begin
            o_x        = i_paddle2.x - BALL_SIZE;
            o_dir_left = 1'b1;
        end else if (i_dir_left && (i_x < SPEED_X)) begin
            o_exit = 1'b1;
        end else if (!i_dir_left && (w_nx > SCREEN_WIDTH)) begin
            o_exit = 1'b1;
        end
    end
endmodule

// File: rtl/ball_motion.sv
// Ball FSM (SERVE -> MOVE -> OUT): serves from centre, steps once per frame_tick, and
// presents the off-screen x for exactly one clk on a miss so the score stage counts once.
module ball_motion
    import ball_motion_pkg::*;
#(
    parameter logic [WIDTH-1:0] SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter logic [WIDTH-1:0] SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter logic [WIDTH-1:0] BALL_SIZE     = DEF_BALL_SIZE,
    parameter logic [WIDTH-1:0] SPEED_X       = DEF_SPEED_X,
    parameter logic [WIDTH-1:0] SPEED_Y       = DEF_SPEED_Y,
    parameter int               SERVE_DELAY   = 120,
    parameter logic             START_LEFT    = 1'b0,
    parameter int               CNT_W         = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  object             paddle1,
    input  object             paddle2,
    input  logic              gameover,
    output object             ball,
    output logic              serving,
    output ball_state_e       o_dbg_state,
    output logic [CNT_W-1:0]  o_dbg_serve_cnt
);
    localparam logic [WIDTH-1:0] CENTRE_X   = (SCREEN_WIDTH >> 1) - (BALL_SIZE >> 1);
    localparam logic [WIDTH-1:0] CENTRE_Y   = (SCREEN_HEIGHT >> 1) - (BALL_SIZE >> 1);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);

    if ((2 * int'(SCREEN_WIDTH) >= (1 << WIDTH) - int'(SPEED_X)) || (SERVE_DELAY < 1)) begin : g_param_check
        $error("ball_motion: WIDTH cannot hold the left-exit wrap, or SERVE_DELAY < 1");
    end

    ball_state_e      r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_dir_left;
    logic             r_dir_up;
    logic [CNT_W-1:0] r_serve_cnt;
    logic             r_serving;

    logic [WIDTH-1:0] w_nx;
    logic [WIDTH-1:0] w_ny;
    logic             w_dir_left;
    logic             w_dir_up;
    logic             w_exit;

    ball_step #(
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT),
        .BALL_SIZE     (BALL_SIZE),
        .SPEED_X       (SPEED_X),
        .SPEED_Y       (SPEED_Y)
    ) u_step (
        .i_x        (r_x),
        .i_y        (r_y),
        .i_dir_left (r_dir_left),
        .i_dir_up   (r_dir_up),
        .i_paddle1  (paddle1),
        .i_paddle2  (paddle2),
        .o_x        (w_nx),
        .o_y        (w_ny),
        .o_dir_left (w_dir_left),
        .o_dir_up   (w_dir_up),
        .o_exit     (w_exit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SERVE;
            r_x         <= CENTRE_X;
            r_y         <= CENTRE_Y;
            r_dir_left  <= START_LEFT;
            r_dir_up    <= 1'b0;
            r_serve_cnt <= '0;
            r_serving   <= 1'b1;
        end else begin
            case (r_state)
                SERVE: begin
                    r_x <= CENTRE_X;
                    r_y <= CENTRE_Y;
                    if (gameover) begin
                        r_serve_cnt <= '0;
                    end else if (frame_tick) begin
                        if (r_serve_cnt == SERVE_LAST) begin
                            r_state     <= MOVE;
                            r_serving   <= 1'b0;
                            r_serve_cnt <= '0;
                        end else begin
                            r_serve_cnt <= r_serve_cnt + CNT_W'(1);
                        end
                    end
                end
                MOVE: begin
                    if (gameover) begin
                        r_state     <= SERVE;
                        r_serving   <= 1'b1;
                        r_x         <= CENTRE_X;
                        r_y         <= CENTRE_Y;
                        r_serve_cnt <= '0;
                    end else if (frame_tick) begin
                        r_x        <= w_nx;
                        r_y        <= w_ny;
                        r_dir_left <= w_dir_left;
                        r_dir_up   <= w_dir_up;
                        if (w_exit) begin
                            r_state <= OUT;
                        end
                    end
                end
                OUT: begin
                    // Directions are kept so the next serve heads toward the player who conceded.
                    r_state     <= SERVE;
                    r_serving   <= 1'b1;
                    r_x         <= CENTRE_X;
                    r_y         <= CENTRE_Y;
                    r_serve_cnt <= '0;
                end
                default: begin
                    r_state   <= SERVE;
                    r_serving <= 1'b1;
                end
            endcase
        end
    end

    assign ball            = '{x: r_x, y: r_y, width: BALL_SIZE, height: BALL_SIZE};
    assign serving         = r_serving;
    assign o_dbg_state     = r_state;
    assign o_dbg_serve_cnt = r_serve_cnt;
endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: one long hand-computed trajectory covering serve, walls,
// paddles, both misses, gameover freeze and reset during OUT, plus a small score-stage model.
module tb_ball_motion;
  import ball_motion_pkg::*;

  localparam int SW_FX = 640 << FBITS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        gameover;
  object       paddle1;
  object       paddle2;
  object       ball;
  logic        serving;
  ball_state_e dbg_state;
  logic [6:0]  dbg_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int k;
  int s1_cnt   = 0;
  int s2_cnt   = 0;

  ball_motion dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_tick      (frame_tick),
    .paddle1         (paddle1),
    .paddle2         (paddle2),
    .gameover        (gameover),
    .ball            (ball),
    .serving         (serving),
    .o_dbg_state     (dbg_state),
    .o_dbg_serve_cnt (dbg_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // score stage model: registered compare of ball.x each clk
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (ball.x > 16'(2 * SW_FX)) s2_cnt <= s2_cnt + 1;
      else if (ball.x > 16'(SW_FX)) s1_cnt <= s1_cnt + 1;
    end
  end

  function automatic logic [15:0] px(input int n);
    return 16'(n << FBITS);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic check_pos(input string tag, input int xp, input int yp);
    check({tag, "_x"}, 32'(ball.x), 32'(px(xp)));
    check({tag, "_y"}, 32'(ball.y), 32'(px(yp)));
  endtask

  task automatic check_centre(input string tag);
    check_pos(tag, 312, 232);
    check({tag, "_state"}, 32'(dbg_state), 32'(SERVE));
    check({tag, "_serving"}, 32'(serving), 32'd1);
    check({tag, "_cnt"}, 32'(dbg_cnt), 32'd0);
  endtask

  // driver tasks: one frame_tick pulse, outputs sampled on the following negedge
  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (k < target) begin
      tick();
      k++;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    gameover   = 1'b0;
    paddle1    = '{x: px(16), y: px(0), width: px(8), height: px(480)};
    paddle2    = '{x: px(600), y: px(0), width: px(8), height: px(480)};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset release and serve delay
    check_centre("reset");
    check("reset_w", 32'(ball.width), 32'(px(16)));
    check("reset_h", 32'(ball.height), 32'(px(16)));
    repeat (119) tick();
    check("serve119_serving", 32'(serving), 32'd1);
    check("serve119_cnt", 32'(dbg_cnt), 32'd119);
    check_pos("serve119", 312, 232);
    tick();
    check("serve120_serving", 32'(serving), 32'd0);
    check("serve120_state", 32'(dbg_state), 32'(MOVE));
    check_pos("serve120", 312, 232);

    // rightward from centre, down, bounce off full-height paddle2 at x=600
    k = 0;
    run_to(1);    check_pos("mv1", 314, 233);
    run_to(136);  check_pos("mv136", 584, 368);
    run_to(137);  check_pos("p2_hit", 584, 369);
    run_to(138);  check_pos("p2_after", 582, 370);
    run_to(231);  check_pos("pre_bottom", 396, 463);
    run_to(232);  check_pos("bottom_wall", 394, 464);
    run_to(233);  check_pos("bottom_after", 392, 463);
    run_to(417);  check("pre_p1_x", 32'(ball.x), 32'(px(24)));
    run_to(418);  check("p1_full_hit_x", 32'(ball.x), 32'(px(24)));
    run_to(419);  check("p1_full_after_x", 32'(ball.x), 32'(px(26)));
    run_to(695);  check_pos("pre_top", 578, 1);
    run_to(696);  check_pos("top_wall", 580, 0);
    run_to(697);  check_pos("top_after", 582, 1);

    // odd paddle2 edge to reach odd x, then paddle1 miss and hit
    paddle2.x = px(601);
    run_to(699);  check("p2_odd_hit_x", 32'(ball.x), 32'(px(585)));
    paddle1 = '{x: px(16), y: px(200), width: px(8), height: px(64)};
    run_to(979);  check_pos("near_p1", 25, 283);
    run_to(980);  check_pos("p1_no_overlap", 23, 284);
    paddle1.height = px(200);
    run_to(981);  check_pos("p1_overlap_hit", 24, 285);
    paddle1 = '{x: px(16), y: px(2000), width: px(8), height: px(64)};
    run_to(1262); check_pos("p2_odd_hit2", 585, 362);

    // left miss: x=1 moving left wraps for one clk
    run_to(1554); check_pos("pre_left_exit", 1, 70);
    run_to(1555);
    check("left_exit_x", 32'(ball.x), 32'h0000_FFF0);
    check("left_exit_y", 32'(ball.y), 32'(px(69)));
    check("left_exit_state", 32'(dbg_state), 32'(OUT));
    check("left_exit_serving", 32'(serving), 32'd0);
    @(negedge clk);
    check_centre("left_reserve");
    repeat (2) @(negedge clk);
    check("left_s2", 32'(s2_cnt), 32'd1);
    check("left_s1", 32'(s1_cnt), 32'd0);

    // re-serve leftward (conceding side), bounce off paddle1 with odd right edge
    paddle1 = '{x: px(16), y: px(0), width: px(9), height: px(480)};
    paddle2 = '{x: px(600), y: px(2000), width: px(8), height: px(64)};
    repeat (120) tick();
    check("serve2_state", 32'(dbg_state), 32'(MOVE));
    k = 0;
    run_to(1);    check_pos("left_mv1", 310, 231);
    run_to(143);  check_pos("pre_p1_odd", 26, 89);
    run_to(144);  check_pos("p1_odd_hit", 25, 88);
    run_to(145);  check("p1_odd_after_x", 32'(ball.x), 32'(px(27)));
    run_to(231);  check_pos("top2_pre", 199, 1);
    run_to(232);  check_pos("top2_wall", 201, 0);
    run_to(451);  check_pos("pre_right_exit", 639, 219);

    // right miss with frame_tick held high through the OUT cycle
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    k++;
    check_pos("right_exit", 641, 220);
    check("right_exit_state", 32'(dbg_state), 32'(OUT));
    @(negedge clk);
    frame_tick = 1'b0;
    check_centre("right_reserve");
    repeat (2) @(negedge clk);
    check("right_s1", 32'(s1_cnt), 32'd1);
    check("right_s2", 32'(s2_cnt), 32'd1);

    // gameover freeze mid-MOVE
    paddle1.y = px(2000);
    paddle1.height = px(64);
    repeat (120) tick();
    k = 0;
    run_to(5);    check_pos("go_pre", 322, 237);
    gameover = 1'b1;
    @(negedge clk);
    check_centre("go_freeze");
    for (int i = 1; i <= 500; i++) begin
      tick();
      if ((i % 100) == 0) begin
        check("go_hold_cnt", 32'(dbg_cnt), 32'd0);
        check("go_hold_x", 32'(ball.x), 32'(px(312)));
        check("go_hold_state", 32'(dbg_state), 32'(SERVE));
      end
    end
    gameover = 1'b0;
    repeat (119) tick();
    check("go_release_cnt", 32'(dbg_cnt), 32'd119);
    tick();
    check("go_release_state", 32'(dbg_state), 32'(MOVE));

    // reset asserted mid-OUT
    k = 0;
    run_to(164);  check_pos("pre_rst_exit", 640, 396);
    run_to(165);
    check("rst_exit_x", 32'(ball.x), 32'(px(642)));
    check("rst_exit_state", 32'(dbg_state), 32'(OUT));
    #1 rst_n = 1'b0;
    #1;
    check_centre("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_cnt", 32'(dbg_cnt), 32'd3);
    check("post_rst_state", 32'(dbg_state), 32'(SERVE));
    check("post_rst_s1", 32'(s1_cnt), 32'd1);
    check("post_rst_s2", 32'(s2_cnt), 32'd1);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
